// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with parity check and FWFT receive FIFO
//
// Purpose:
//   Oversampling UART receiver (CLKS_PER_BIT clocks per bit). Each frame
//   contains a start bit, DATA_BITS data bits, an optional parity bit and a
//   stop bit. Good frames are pushed into a first-word-fall-through FIFO
//   together with their parity-error tag.
//
// Ports:
//   clk        in   sole clock, rising edge
//   btn        in   synchronous active-low reset
//   uart_rx    in   asynchronous serial line, idle high
//   rx_data    out  FIFO head data word (0 while empty)
//   rx_perr    out  parity-error tag of FIFO head word (0 while empty)
//   rx_valid   out  FIFO non-empty
//   rx_ready   in   consumer accepts head word (pop on rx_valid & rx_ready)
//   frame_err  out  one-cycle pulse when a stop bit samples low
//   overflow   out  sticky: a word was dropped because the FIFO was full
//   fifo_count out  number of entries held

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int MSB_FIRST    = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          btn,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizer; both flops reset to the idle line level so a reset
  // never manufactures a falling edge.
  // ---------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_rxs;

  always_ff @(posedge clk) begin
    if (!btn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_clk_cnt;
  logic [IW-1:0]   r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic            r_perr;

  logic w_half_tick;
  logic w_bit_tick;
  logic w_last_bit;

  assign w_half_tick = (r_clk_cnt == CNT_HALF);
  assign w_bit_tick  = (r_clk_cnt == CNT_LAST);
  assign w_last_bit  = (r_bit_idx == IDX_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!btn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (w_half_tick) begin
          w_state_next = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_tick && w_last_bit) begin
          w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_bit_tick) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Returning to IDLE at the stop-bit centre leaves half a bit of
        // margin to catch a back-to-back start edge.
        if (w_bit_tick) begin
          w_state_next = w_rxs ? S_IDLE : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (w_rxs) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output / control decode
  logic w_push;
  logic w_frame_err;
  logic w_sample_data;
  logic w_sample_par;
  logic w_cnt_clear;

  always_comb begin
    w_push        = 1'b0;
    w_frame_err   = 1'b0;
    w_sample_data = 1'b0;
    w_sample_par  = 1'b0;
    w_cnt_clear   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clear = 1'b1;
      end
      S_START: begin
        w_cnt_clear = w_half_tick;
      end
      S_DATA: begin
        w_sample_data = w_bit_tick;
        w_cnt_clear   = w_bit_tick;
      end
      S_PARITY: begin
        w_sample_par = w_bit_tick;
        w_cnt_clear  = w_bit_tick;
      end
      S_STOP: begin
        w_push      = w_bit_tick && w_rxs;
        w_frame_err = w_bit_tick && !w_rxs;
        w_cnt_clear = w_bit_tick;
      end
      S_WAIT_IDLE: begin
        w_cnt_clear = 1'b1;
      end
      default: begin
        w_cnt_clear = 1'b1;
      end
    endcase
  end

  assign frame_err = w_frame_err;

  // Bit-period counter
  always_ff @(posedge clk) begin
    if (!btn) begin
      r_clk_cnt <= '0;
    end else if (w_cnt_clear) begin
      r_clk_cnt <= '0;
    end else begin
      r_clk_cnt <= r_clk_cnt + CW'(1);
    end
  end

  // Data bit index; only meaningful while in DATA
  always_ff @(posedge clk) begin
    if (!btn) begin
      r_bit_idx <= '0;
    end else if (w_sample_data) begin
      r_bit_idx <= w_last_bit ? '0 : r_bit_idx + IW'(1);
    end else if (r_state != S_DATA) begin
      r_bit_idx <= '0;
    end
  end

  // Data shift register. LSB-first shifts right so the first bit lands in
  // bit 0 after DATA_BITS samples; MSB-first shifts left so it lands on top.
  always_ff @(posedge clk) begin
    if (!btn) begin
      r_shift <= '0;
    end else if (w_sample_data) begin
      if (MSB_FIRST != 0) begin
        r_shift <= {r_shift[DATA_BITS-2:0], w_rxs};
      end else begin
        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  // Parity error flag, cleared at the start of every frame so parity-less
  // configurations always tag words clean.
  always_ff @(posedge clk) begin
    if (!btn) begin
      r_perr <= 1'b0;
    end else if (r_state == S_START) begin
      r_perr <= 1'b0;
    end else if (w_sample_par) begin
      if (PARITY == 1) begin
        r_perr <= ~(^r_shift ^ w_rxs);
      end else begin
        r_perr <= ^r_shift ^ w_rxs;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  logic [DATA_BITS:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_overflow;

  logic               w_full;
  logic               w_pop;
  logic               w_wr_en;
  logic [DATA_BITS:0] w_head;

  assign rx_valid = (r_count != '0);
  assign w_full   = (r_count == CNT_FULL);
  assign w_pop    = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr_en  = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {r_perr, r_shift};
    end
  end

  always_ff @(posedge clk) begin
    if (!btn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr_en) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Memory is not reset, so the head is masked while empty.
  assign w_head     = r_mem[r_rd_ptr];
  assign rx_data    = rx_valid ? w_head[DATA_BITS-1:0] : '0;
  assign rx_perr    = rx_valid & w_head[DATA_BITS];
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       btn;
  logic       rx    [3];
  logic       rdy   [3];
  logic [7:0] dat   [3];
  logic       perr  [3];
  logic       vld   [3];
  logic       ferr  [3];
  logic       ovf   [3];
  logic [2:0] cnt   [3];

  always #5 clk = ~clk;

  // 0: defaults, 1: MSB first, 2: even parity
  uart_rx_fifo u_def (
    .clk(clk), .btn(btn), .uart_rx(rx[0]), .rx_data(dat[0]), .rx_perr(perr[0]),
    .rx_valid(vld[0]), .rx_ready(rdy[0]), .frame_err(ferr[0]), .overflow(ovf[0]),
    .fifo_count(cnt[0]));

  uart_rx_fifo #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .btn(btn), .uart_rx(rx[1]), .rx_data(dat[1]), .rx_perr(perr[1]),
    .rx_valid(vld[1]), .rx_ready(rdy[1]), .frame_err(ferr[1]), .overflow(ovf[1]),
    .fifo_count(cnt[1]));

  uart_rx_fifo #(.PARITY(2)) u_par (
    .clk(clk), .btn(btn), .uart_rx(rx[2]), .rx_data(dat[2]), .rx_perr(perr[2]),
    .rx_valid(vld[2]), .rx_ready(rdy[2]), .frame_err(ferr[2]), .overflow(ovf[2]),
    .fifo_count(cnt[2]));

  // Capture of popped words, frame_err cycles and valid cycles per instance.
  // Sampled after the bench has driven inputs for the coming rising edge.
  logic [8:0] cap [3][64];
  int         wr  [3] = '{0, 0, 0};
  int         fe  [3] = '{0, 0, 0};
  int         vc  [3] = '{0, 0, 0};

  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      if (btn && vld[k] && rdy[k] && wr[k] < 64) begin
        cap[k][wr[k]] <= {perr[k], dat[k]};
        wr[k]         <= wr[k] + 1;
      end
      if (btn && ferr[k]) fe[k] <= fe[k] + 1;
      if (btn && vld[k])  vc[k] <= vc[k] + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int k, input logic [9:0] bits, input int n, input logic stop);
    rx[k] = 1'b0;
    step(CPB);
    for (int i = 0; i < n; i++) begin
      rx[k] = bits[i];
      step(CPB);
    end
    rx[k] = stop;
    step(CPB);
  endtask

  // bits: line order, bit 0 transmitted first (parity bit, if any, is bit 8)
  typedef struct {
    int         k;
    logic [9:0] bits;
    int         n;
    logic [7:0] exp_d;
    logic       exp_p;
  } vec_t;

  vec_t vecs [11];

  int w0, f0, v0;

  initial begin
    vecs[0]  = '{0, 10'h055, 8, 8'h55, 1'b0};
    vecs[1]  = '{0, 10'h0A3, 8, 8'hA3, 1'b0};
    vecs[2]  = '{0, 10'h000, 8, 8'h00, 1'b0};
    vecs[3]  = '{0, 10'h0FF, 8, 8'hFF, 1'b0};
    vecs[4]  = '{1, 10'h055, 8, 8'hAA, 1'b0};
    vecs[5]  = '{1, 10'h0AA, 8, 8'h55, 1'b0};
    vecs[6]  = '{1, 10'h001, 8, 8'h80, 1'b0};
    vecs[7]  = '{2, 10'h103, 9, 8'h03, 1'b1};
    vecs[8]  = '{2, 10'h003, 9, 8'h03, 1'b0};
    vecs[9]  = '{2, 10'h107, 9, 8'h07, 1'b0};
    vecs[10] = '{2, 10'h007, 9, 8'h07, 1'b1};

    btn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rx[k]  = 1'b1;
      rdy[k] = 1'b1;
    end
    step(4);

    // Reset state
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid%0d", k), int'(vld[k]), 0);
      check($sformatf("rst_count%0d", k), int'(cnt[k]), 0);
      check($sformatf("rst_ferr%0d", k), int'(ferr[k]), 0);
      check($sformatf("rst_ovf%0d", k), int'(ovf[k]), 0);
      check($sformatf("rst_data%0d", k), int'(dat[k]), 0);
      check($sformatf("rst_perr%0d", k), int'(perr[k]), 0);
    end
    btn = 1'b1;
    step(4);

    // Table-driven single frames with rx_ready held high
    for (int i = 0; i < 11; i++) begin
      w0 = wr[vecs[i].k];
      f0 = fe[vecs[i].k];
      v0 = vc[vecs[i].k];
      send_frame(vecs[i].k, vecs[i].bits, vecs[i].n, 1'b1);
      step(6);
      check($sformatf("v%0d_pops", i), wr[vecs[i].k] - w0, 1);
      if (wr[vecs[i].k] - w0 >= 1) begin
        check($sformatf("v%0d_data", i), int'(cap[vecs[i].k][w0][7:0]), int'(vecs[i].exp_d));
        check($sformatf("v%0d_perr", i), int'(cap[vecs[i].k][w0][8]), int'(vecs[i].exp_p));
      end
      check($sformatf("v%0d_ferr", i), fe[vecs[i].k] - f0, 0);
      check($sformatf("v%0d_vcycles", i), vc[vecs[i].k] - v0, 1);
    end

    // MSB-first back-to-back with a 3-clock gap after the stop bit
    w0 = wr[1];
    send_frame(1, 10'h055, 8, 1'b1);
    step(3);
    send_frame(1, 10'h0AA, 8, 1'b1);
    step(6);
    check("msb_b2b_pops", wr[1] - w0, 2);
    if (wr[1] - w0 >= 2) begin
      check("msb_b2b_first", int'(cap[1][w0][7:0]), 8'hAA);
      check("msb_b2b_second", int'(cap[1][w0+1][7:0]), 8'h55);
    end

    // False start: 2 clocks low, then a real frame must still decode
    w0 = wr[0];
    f0 = fe[0];
    rx[0] = 1'b0;
    step(2);
    rx[0] = 1'b1;
    step(20);
    check("glitch_pops", wr[0] - w0, 0);
    check("glitch_ferr", fe[0] - f0, 0);
    check("glitch_count", int'(cnt[0]), 0);
    send_frame(0, 10'h05A, 8, 1'b1);
    step(6);
    check("glitch_then_pops", wr[0] - w0, 1);
    if (wr[0] - w0 >= 1) check("glitch_then_data", int'(cap[0][w0][7:0]), 8'h5A);

    // Bad stop bit, line held low 40 clocks, then a good frame
    w0 = wr[0];
    f0 = fe[0];
    send_frame(0, 10'h03C, 8, 1'b0);
    step(40);
    rx[0] = 1'b1;
    step(10);
    send_frame(0, 10'h012, 8, 1'b1);
    step(6);
    check("ferr_pulses", fe[0] - f0, 1);
    check("ferr_pops", wr[0] - w0, 1);
    if (wr[0] - w0 >= 1) check("ferr_next_data", int'(cap[0][w0][7:0]), 8'h12);

    // Overflow: five frames into a four-entry FIFO with rx_ready low
    rdy[0] = 1'b0;
    w0 = wr[0];
    for (int v = 1; v <= 5; v++) send_frame(0, 10'(v), 8, 1'b1);
    step(4);
    check("ovf_count", int'(cnt[0]), 4);
    check("ovf_flag", int'(ovf[0]), 1);
    check("ovf_valid", int'(vld[0]), 1);
    check("ovf_head", int'(dat[0]), 8'h01);
    rdy[0] = 1'b1;
    step(10);
    check("ovf_pops", wr[0] - w0, 4);
    for (int j = 0; j < 4; j++) begin
      if (wr[0] - w0 > j) check($sformatf("ovf_pop%0d", j), int'(cap[0][w0+j][7:0]), j + 1);
    end
    check("ovf_drained", int'(cnt[0]), 0);
    check("ovf_sticky", int'(ovf[0]), 1);

    // Reset with a word held flushes FIFO and clears overflow
    rdy[0] = 1'b0;
    send_frame(0, 10'h077, 8, 1'b1);
    step(4);
    check("hold_count", int'(cnt[0]), 1);
    btn = 1'b0;
    step(1);
    check("rst2_count", int'(cnt[0]), 0);
    check("rst2_valid", int'(vld[0]), 0);
    check("rst2_data", int'(dat[0]), 0);
    check("rst2_ovf", int'(ovf[0]), 0);
    btn = 1'b1;
    rdy[0] = 1'b1;
    step(4);

    // Reset mid-frame: remaining bits are all high, so nothing may appear
    w0 = wr[0];
    f0 = fe[0];
    rx[0] = 1'b0;
    step(CPB);
    rx[0] = 1'b1;
    step(4);
    btn = 1'b0;
    step(1);
    btn = 1'b1;
    step(CPB * 9 + 10);
    check("midrst_pops", wr[0] - w0, 0);
    check("midrst_ferr", fe[0] - f0, 0);
    check("midrst_count", int'(cnt[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
